// File: rtl/seven_segment_4_digit_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver showing a 16-bit value as hex.
// Outputs registered (1-cycle latency from number/index); free-running scan, no backpressure.
module seven_segment_4_digit_display #(
  parameter int DIVIDER = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] number,
  output logic [7:0]  abcdefgh,
  output logic [3:0]  digit
);

  localparam int W = $clog2(DIVIDER);
  localparam logic [W-1:0] LAST = W'(DIVIDER - 1);

  logic [W-1:0] r_prescaler;
  logic [1:0]   r_index;
  logic [3:0]   r_digit;
  logic [7:0]   r_abcdefgh;
  logic [3:0]   w_nibble;
  logic [7:0]   w_seg;

  assign w_nibble = number[{r_index, 2'b00} +: 4];

  // Active-high abcdefgh pattern; dp (bit0) is never lit.
  always_comb begin
    w_seg = 8'h00;
    case (w_nibble)
      4'h0: w_seg = 8'hFC;
      4'h1: w_seg = 8'h60;
      4'h2: w_seg = 8'hDA;
      4'h3: w_seg = 8'hF2;
      4'h4: w_seg = 8'h66;
      4'h5: w_seg = 8'hB6;
      4'h6: w_seg = 8'hBE;
      4'h7: w_seg = 8'hE0;
      4'h8: w_seg = 8'hFE;
      4'h9: w_seg = 8'hF6;
      4'hA: w_seg = 8'hEE;
      4'hB: w_seg = 8'h3E;
      4'hC: w_seg = 8'h9C;
      4'hD: w_seg = 8'h7A;
      4'hE: w_seg = 8'h9E;
      default: w_seg = 8'h8E;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_index     <= 2'd0;
      r_digit     <= 4'b1111;
      r_abcdefgh  <= 8'hFF;
    end else begin
      if (r_prescaler == LAST) begin
        r_prescaler <= '0;
        r_index     <= r_index + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + W'(1);
      end
      r_digit    <= ~(4'b0001 << r_index);
      r_abcdefgh <= ~w_seg;
    end
  end

  assign digit    = r_digit;
  assign abcdefgh = r_abcdefgh;

endmodule

// File: tb/tb_seven_segment_4_digit_display.sv
// Directed bench for the 4-digit display driver, scanned with DIVIDER=4.
module tb_seven_segment_4_digit_display;

  logic        clock;
  logic        reset;
  logic [15:0] number;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;

  int total;
  int bad;

  seven_segment_4_digit_display #(.DIVIDER(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .number   (number),
    .abcdefgh (abcdefgh),
    .digit    (digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Active-low segment codes, inverted by hand from the a..h table.
  function automatic logic [7:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: exp_seg = 8'h03;
      4'h1: exp_seg = 8'h9F;
      4'h2: exp_seg = 8'h25;
      4'h3: exp_seg = 8'h0D;
      4'h4: exp_seg = 8'h99;
      4'h5: exp_seg = 8'h49;
      4'h6: exp_seg = 8'h41;
      4'h7: exp_seg = 8'h1F;
      4'h8: exp_seg = 8'h01;
      4'h9: exp_seg = 8'h09;
      4'hA: exp_seg = 8'h11;
      4'hB: exp_seg = 8'hC1;
      4'hC: exp_seg = 8'h63;
      4'hD: exp_seg = 8'h85;
      4'hE: exp_seg = 8'h61;
      default: exp_seg = 8'h71;
    endcase
  endfunction

  function automatic logic [3:0] exp_dig(input int idx);
    case (idx)
      0: exp_dig = 4'b1110;
      1: exp_dig = 4'b1101;
      2: exp_dig = 4'b1011;
      default: exp_dig = 4'b0111;
    endcase
  endfunction

  // Pulse reset on a falling edge; the next rising edge is the first scan cycle.
  task automatic do_reset(input logic [15:0] val);
    @(negedge clock);
    reset  = 1'b1;
    number = val;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    number = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++;
      if (digit !== 4'hF) begin
        bad++;
        $display("FAIL reset_digit cyc=%0d got=%b want=1111", c, digit);
      end
      total++;
      if (abcdefgh !== 8'hFF) begin
        bad++;
        $display("FAIL reset_seg cyc=%0d got=%h want=ff", c, abcdefgh);
      end
    end
  endtask

  // Expects a value whose four nibbles map to the given codes, digit0 first.
  task automatic scan_check(input string name, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input int cycles);
    logic [7:0] want_seg [4];
    want_seg[0] = s0; want_seg[1] = s1; want_seg[2] = s2; want_seg[3] = s3;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      total++;
      if (digit !== exp_dig((c / 4) % 4)) begin
        bad++;
        $display("FAIL %s_digit cyc=%0d got=%b want=%b", name, c, digit, exp_dig((c / 4) % 4));
      end
      total++;
      if (abcdefgh !== want_seg[(c / 4) % 4]) begin
        bad++;
        $display("FAIL %s_seg cyc=%0d got=%h want=%h", name, c, abcdefgh, want_seg[(c / 4) % 4]);
      end
    end
  endtask

  task automatic test_scan_1234();
    @(negedge clock);
    reset = 1'b0;
    scan_check("scan1234", 8'h99, 8'h0D, 8'h25, 8'h9F, 17);
  endtask

  task automatic test_8f0a();
    do_reset(16'h8F0A);
    scan_check("scan8f0a", 8'h11, 8'h03, 8'h71, 8'h01, 16);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      do_reset({12'h000, 4'(v)});
      @(negedge clock);
      total++;
      if (digit !== 4'b1110) begin
        bad++;
        $display("FAIL sweep_digit nib=%0h got=%b want=1110", v, digit);
      end
      total++;
      if (abcdefgh !== exp_seg(4'(v)) || abcdefgh[0] !== 1'b1) begin
        bad++;
        $display("FAIL sweep_seg nib=%0h got=%h want=%h", v, abcdefgh, exp_seg(4'(v)));
      end
    end
  endtask

  task automatic test_midchange();
    do_reset(16'h1234);
    repeat (9) @(negedge clock);
    total++;
    if (digit !== 4'b1011 || abcdefgh !== 8'h25) begin
      bad++;
      $display("FAIL midchg_before got=%b/%h want=1011/25", digit, abcdefgh);
    end
    number = 16'h1934;
    @(negedge clock);
    total++;
    if (digit !== 4'b1011) begin
      bad++;
      $display("FAIL midchg_digit got=%b want=1011", digit);
    end
    total++;
    if (abcdefgh !== 8'h09) begin
      bad++;
      $display("FAIL midchg_seg got=%h want=09", abcdefgh);
    end
  endtask

  task automatic test_async_reset();
    do_reset(16'h1234);
    repeat (6) @(negedge clock);
    total++;
    if (digit !== 4'b1101) begin
      bad++;
      $display("FAIL areset_pre got=%b want=1101", digit);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (digit !== 4'hF || abcdefgh !== 8'hFF) begin
      bad++;
      $display("FAIL areset_dark got=%b/%h want=1111/ff", digit, abcdefgh);
    end
    @(negedge clock);
    reset = 1'b0;
    scan_check("restart", 8'h99, 8'h0D, 8'h25, 8'h9F, 5);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    number = 16'h0000;
    test_reset();
    test_scan_1234();
    test_8f0a();
    test_sweep();
    test_midchange();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
